// File: rtl/collisions_reader.sv
// Read-side master for the collision-record BRAM: fetches COUNT records from BASE
// through port B and serialises each into WORD_WIDTH words on a valid/ready stream.
//
// state   | meaning
// IDLE    | waiting for start; base/count latched on accept
// ISSUE   | read strobe (ceb) asserted at the current address
// CAPTURE | BRAM data arrives; latched into the record buffer
// EMIT    | record words presented low word first, one per handshake
// FINISH  | one-cycle done pulse, then back to IDLE
module collisions_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_ceb,
  output logic [ADDR_WIDTH-1:0] bram_adb,
  output logic                  bram_oce,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_valid,
  input  logic                  word_ready
);

  localparam int NWORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_EMIT,
    S_FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      remain_q, remain_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [WORD_WIDTH-1:0] words [NWORDS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      idx_q    <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = count;
          idx_d    = '0;
          state_d  = (count == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        buf_d    = bram_dout;
        remain_d = remain_q - CNT_W'(1);
        // natural overflow gives the 1023 -> 0 wrap
        addr_d   = addr_q + ADDR_WIDTH'(1);
        state_d  = S_EMIT;
      end
      S_EMIT: begin
        if (word_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (remain_q != '0) ? S_ISSUE : S_FINISH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NWORDS; i++) begin
      words[i] = buf_q[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  assign busy       = (state_q == S_ISSUE) || (state_q == S_CAPTURE) || (state_q == S_EMIT);
  assign done       = (state_q == S_FINISH);
  assign bram_ceb   = (state_q == S_ISSUE);
  assign bram_adb   = addr_q;
  assign bram_oce   = 1'b1;
  assign word_valid = (state_q == S_EMIT);
  assign word_out   = word_valid ? words[idx_q] : '0;

endmodule

// File: tb/tb_collisions_reader.sv
// Bench for collisions_reader: BRAM model, stream monitor and a queue-based
// reference built from the memory contents, base and count.
module tb_collisions_reader;

  localparam int AW = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          busy, done, bram_ceb, bram_oce, word_valid, word_ready;
  logic [AW-1:0] bram_adb;
  logic [63:0]   bram_dout;
  logic [15:0]   word_out;

  collisions_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(64), .WORD_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .bram_ceb(bram_ceb), .bram_adb(bram_adb), .bram_oce(bram_oce),
    .bram_dout(bram_dout), .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [DEPTH];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bram_ceb) bram_dout <= mem[bram_adb];

  // 0: ready low, 1: ready high, 2: random
  int ready_mode = 1;
  initial begin
    word_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 2) word_ready = 1'($urandom_range(0, 1));
      else word_ready = (ready_mode == 1);
    end
  end

  logic [15:0]   got_words [$];
  logic [AW-1:0] got_addrs [$];
  int  done_cnt = 0, done_cyc = 0, last_hs_cyc = 0, stab_viol = 0;
  bit  busy_seen = 0, hold_valid = 0;
  logic [15:0] hold_word;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bram_ceb) got_addrs.push_back(bram_adb);
      if (busy) busy_seen = 1;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (hold_valid && (!word_valid || word_out !== hold_word)) stab_viol++;
      if (word_valid && word_ready) begin got_words.push_back(word_out); last_hs_cyc = cyc; end
      hold_valid = word_valid && !word_ready;
      hold_word  = word_out;
    end else begin
      hold_valid = 0;
    end
  end

  int errors = 0, checks = 0;
  int launch_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    got_words.delete();
    got_addrs.delete();
    done_cnt = 0;
    busy_seen = 0;
    stab_viol = 0;
  endtask

  task automatic launch(input int b, input int c);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = AW'(b);
    count = (AW+1)'(c);
    launch_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (!word_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid_seen"}, 64'(word_valid), 64'd1);
  endtask

  task automatic verify(input int b, input int c, input bit timed, input string tag);
    logic [15:0]   exp_words [$];
    logic [AW-1:0] exp_addrs [$];
    logic [63:0]   rec;
    int nw, na;
    for (int r = 0; r < c; r++) begin
      rec = mem[(b + r) % DEPTH];
      exp_addrs.push_back(AW'((b + r) % DEPTH));
      for (int w = 0; w < 4; w++) exp_words.push_back(rec[16*w +: 16]);
    end
    chk({tag, "_nwords"}, 64'(got_words.size()), 64'(exp_words.size()));
    chk({tag, "_nreads"}, 64'(got_addrs.size()), 64'(exp_addrs.size()));
    nw = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
    na = (got_addrs.size() < exp_addrs.size()) ? got_addrs.size() : exp_addrs.size();
    for (int i = 0; i < nw; i++) chk($sformatf("%s_word%0d", tag, i), 64'(got_words[i]), 64'(exp_words[i]));
    for (int i = 0; i < na; i++) chk($sformatf("%s_adb%0d", tag, i), 64'(got_addrs[i]), 64'(exp_addrs[i]));
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_stable"}, 64'(stab_viol), 64'd0);
    if (c == 0) chk({tag, "_done_time"}, 64'(done_cyc), 64'(launch_cyc + 1));
    else chk({tag, "_done_after_hs"}, 64'(done_cyc), 64'(last_hs_cyc + 1));
    if (timed) chk({tag, "_latency"}, 64'(done_cyc), 64'(launch_cyc + 1 + 6 * c));
  endtask

  initial begin
    int b, c;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    mem[5] = 64'h4444_3333_2222_1111;
    bram_dout = '0;
    reset_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ceb", 64'(bram_ceb), 64'd0);
    chk("rst_valid", 64'(word_valid), 64'd0);
    chk("rst_adb", 64'(bram_adb), 64'd0);
    chk("rst_word", 64'(word_out), 64'd0);
    chk("oce", 64'(bram_oce), 64'd1);
    reset_n = 1'b1;

    // T2 single record
    ready_mode = 1;
    repeat (2) @(negedge clk);
    clear_obs();
    launch(5, 1);
    wait_done(100, "t2");
    verify(5, 1, 1, "t2");

    // T3 backpressure over two records
    ready_mode = 2;
    clear_obs();
    launch(0, 2);
    wait_done(400, "t3");
    verify(0, 2, 0, "t3");

    // T4 address wrap
    ready_mode = 1;
    repeat (2) @(negedge clk);
    clear_obs();
    launch(1023, 2);
    wait_done(100, "t4");
    verify(1023, 2, 1, "t4");

    // T5 zero count
    clear_obs();
    launch(7, 0);
    wait_done(20, "t5");
    verify(7, 0, 0, "t5");
    chk("t5_busy_never", 64'(busy_seen), 64'd0);

    // T6 start while busy is ignored
    ready_mode = 0;
    repeat (2) @(negedge clk);
    clear_obs();
    launch(20, 2);
    wait_valid(20, "t6a");
    launch(100, 5);
    ready_mode = 2;
    wait_done(400, "t6a");
    verify(20, 2, 0, "t6a");
    ready_mode = 1;
    repeat (2) @(negedge clk);
    clear_obs();
    launch(10, 1);
    wait_done(100, "t6b");
    verify(10, 1, 1, "t6b");

    // randomized transfers under random backpressure
    ready_mode = 2;
    for (int k = 0; k < 4; k++) begin
      b = $urandom_range(0, DEPTH - 1);
      c = $urandom_range(1, 6);
      clear_obs();
      launch(b, c);
      wait_done(60 * c + 50, $sformatf("rnd%0d", k));
      verify(b, c, 0, $sformatf("rnd%0d", k));
    end

    // full-depth transfer from a non-zero base
    ready_mode = 1;
    repeat (2) @(negedge clk);
    clear_obs();
    launch(700, 1024);
    wait_done(7000, "full");
    verify(700, 1024, 1, "full");

    // T1 asynchronous reset mid-EMIT
    ready_mode = 0;
    repeat (2) @(negedge clk);
    clear_obs();
    launch(3, 2);
    wait_valid(20, "t1");
    #2;
    reset_n = 1'b0;
    #1;
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_done", 64'(done), 64'd0);
    chk("t1_valid", 64'(word_valid), 64'd0);
    chk("t1_ceb", 64'(bram_ceb), 64'd0);
    chk("t1_word", 64'(word_out), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ready_mode = 1;
    clear_obs();
    repeat (10) @(negedge clk);
    chk("t1_no_words", 64'(got_words.size()), 64'd0);
    chk("t1_no_reads", 64'(got_addrs.size()), 64'd0);
    chk("t1_no_done", 64'(done_cnt), 64'd0);
    chk("t1_idle", 64'(busy_seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
